writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage; sits directly downstream of the MEMORY stage and consumes its write-back outputs.
- Registers the MEM/WB boundary and selects the register-bank write data and destination.
- Drives the register-bank write port and the forwarding unit.
- Owns the processor halt state machine and the retired-instruction/cycle counters read by the DEBUG UNIT.

Parameters:
- NB_DATA, 32, data width
- NB_PC, 32, PC width
- NB_REG, 5, register index width
- NB_CNT, 32, counter width
- LAST_REG, 31, destination index used when last-register control is set (link register)

Ports:
- i_clock  in  1  system clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_enable  in  1  DEBUG UNIT step/run enable; 0 = stage frozen
- i_valid  in  1  MEM stage holds a real instruction (0 = bubble)
- i_mem_data  in  NB_DATA  load data from MEM (already sign/size adjusted)
- i_alu_result  in  NB_DATA  ALU result from MEM
- i_selected_reg  in  NB_REG  destination register (rd or rt)
- i_reg_write  in  1  write-back enable
- i_mem_to_reg  in  1  1 = write load data, 0 = ALU result
- i_last_register_ctrl  in  1  write i_pc into LAST_REG (JAL/JALR)
- i_pc  in  NB_PC  return PC from MEM
- i_halt  in  1  instruction is HALT
- o_wb_data  out  NB_DATA  register-bank write data
- o_wb_reg  out  NB_REG  register-bank write index
- o_wb_write  out  1  register-bank write strobe / forwarding valid
- o_halt  out  1  processor halted (sticky)
- o_retired  out  NB_CNT  retired-instruction count
- o_cycles  out  NB_CNT  active-cycle count

Behaviour:
- Reset (i_reset=0 at a rising edge): latch cleared (valid, reg_write, mem_to_reg, last_reg_ctrl, halt = 0; data, reg, pc = 0); state = RUN; counters = 0.
  - Resulting outputs: o_wb_data=0, o_wb_reg=0, o_wb_write=0, o_halt=0, o_retired=0, o_cycles=0.
  - Reset has priority over every other input, including while HALTED.
- FSM states: RUN, HALTED.
  - RUN to HALTED: on the edge where i_enable=1, i_valid=1 and i_halt=1.
  - HALTED is left only by reset.
- Latch capture: on every edge with state=RUN and i_enable=1, all MEM inputs are captured.
  - Otherwise (i_enable=0, or HALTED) the latch holds its value.
  - Latency: MEM values appear on the write port one cycle after capture.
- Write-back selection (combinational from latch):
  - o_wb_data: pc if last_reg_ctrl; else mem_data if mem_to_reg; else alu_result. last_reg_ctrl has priority over mem_to_reg.
  - o_wb_reg: LAST_REG if last_reg_ctrl, else latched reg.
- o_wb_write = latched valid & latched reg_write & (o_wb_reg != 0) & state==RUN.
  - Writes to register 0 are always suppressed.
  - While i_enable=0 the strobe stays asserted on the held latch. The repeated write is idempotent and is the required behaviour, so a write is not lost when a stall follows capture.
- o_halt = (state==HALTED), registered.
  - The HALT instruction's own reg_write is ignored, because state is HALTED when it would be presented.
  - Instructions captured before the HALT complete normally.
- o_retired: +1 on each capture with i_valid=1, HALT included; bubbles are not counted.
- o_cycles: +1 on every edge with state=RUN and i_enable=1.
- Both counters saturate at all-ones (no wrap) and freeze in HALTED.
- When i_valid=0 (bubble) is captured, o_wb_write=0 regardless of the other latched control bits.

Test Plan:
- Reset, then ALU write (i_valid=1, i_reg_write=1, i_mem_to_reg=0, i_alu_result=0x0000_00A5, i_selected_reg=3) -> next cycle o_wb_write=1, o_wb_reg=3, o_wb_data=0xA5; o_retired=1, o_cycles=1.
- Load (i_mem_to_reg=1, i_mem_data=0xFFFF_FF80, i_alu_result=0x10, reg 7), followed by a JAL (i_last_register_ctrl=1, i_mem_to_reg=1, i_pc=0x0000_0024, reg 5):
  - load -> o_wb_data=0xFFFF_FF80, o_wb_reg=7;
  - JAL -> o_wb_reg=31, o_wb_data=0x24 (last-register priority).
- Write to reg 0 (i_selected_reg=0, i_reg_write=1), and a bubble (i_valid=0, i_reg_write=1, reg 4) -> o_wb_write=0 for both; o_retired counts only the reg-0 instruction.
- Stall: capture ADD to reg 2, then i_enable=0 for 3 cycles while MEM inputs change -> o_wb_reg=2 with the original data for all 3 cycles; o_cycles and o_retired unchanged; the new inputs are captured on the first i_enable=1 edge.
- HALT sequence (ADD reg 1, HALT with i_reg_write=1 reg 9, ADD reg 2):
  - ADD reg 1 writes;
  - o_halt=1 from the edge after HALT capture;
  - reg 9 and reg 2 are never written;
  - o_retired=2 and frozen;
  - i_reset=0 for one edge -> o_halt=0, counters 0.
- Counter saturation (preload via forced NB_CNT=4): 20 enabled cycles -> o_cycles stays 0xF after reaching it and does not wrap.

Source files
------------

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : MEM/WB boundary register, write-back select, halt FSM and
//            retired/cycle counters for the debug unit.
// Revision : 1.0
// ============================================================================
module writeback_stage #(
    parameter int NB_DATA  = 32,
    parameter int NB_PC    = 32,
    parameter int NB_REG   = 5,
    parameter int NB_CNT   = 32,
    parameter int LAST_REG = 31
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_REG-1:0]  i_selected_reg,
    input  logic               i_reg_write,
    input  logic               i_mem_to_reg,
    input  logic               i_last_register_ctrl,
    input  logic [NB_PC-1:0]   i_pc,
    input  logic               i_halt,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic [NB_REG-1:0]  o_wb_reg,
    output logic               o_wb_write,
    output logic               o_halt,
    output logic [NB_CNT-1:0]  o_retired,
    output logic [NB_CNT-1:0]  o_cycles
);

    localparam logic [0:0]        c_st_run    = 1'b0;
    localparam logic [0:0]        c_st_halted = 1'b1;
    localparam logic [NB_REG-1:0] c_last_reg  = NB_REG'(LAST_REG);
    localparam logic [NB_CNT-1:0] c_cnt_max   = '1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic               w_capture;

    logic               r_valid;
    logic               r_reg_write;
    logic               r_mem_to_reg;
    logic               r_last_reg_ctrl;
    logic               r_halt;
    logic [NB_DATA-1:0] r_mem_data;
    logic [NB_DATA-1:0] r_alu_result;
    logic [NB_REG-1:0]  r_selected_reg;
    logic [NB_PC-1:0]   r_pc;

    logic [NB_CNT-1:0]  r_retired;
    logic [NB_CNT-1:0]  r_cycles;

    logic [NB_DATA-1:0] w_wb_data;
    logic [NB_REG-1:0]  w_wb_reg;

    assign w_capture = i_enable && (r_state == c_st_run);

    // ------------------------------------------------------------------
    // Halt FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_run: begin
                if (i_enable && i_valid && i_halt) begin
                    w_state_next = c_st_halted;
                end
            end
            c_st_halted: begin
                w_state_next = c_st_halted;
            end
            default: begin
                w_state_next = c_st_run;
            end
        endcase
    end

    // HALTED also blocks the HALT instruction's own write from reaching the bank
    always_comb begin
        o_halt     = 1'b0;
        o_wb_write = 1'b0;
        case (r_state)
            c_st_run: begin
                o_wb_write = r_valid && r_reg_write && (w_wb_reg != '0);
            end
            c_st_halted: begin
                o_halt = 1'b1;
            end
            default: begin
                o_halt     = 1'b0;
                o_wb_write = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB boundary register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_valid         <= 1'b0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_last_reg_ctrl <= 1'b0;
            r_halt          <= 1'b0;
            r_mem_data      <= '0;
            r_alu_result    <= '0;
            r_selected_reg  <= '0;
            r_pc            <= '0;
        end else if (w_capture) begin
            r_valid         <= i_valid;
            r_reg_write     <= i_reg_write;
            r_mem_to_reg    <= i_mem_to_reg;
            r_last_reg_ctrl <= i_last_register_ctrl;
            r_halt          <= i_halt;
            r_mem_data      <= i_mem_data;
            r_alu_result    <= i_alu_result;
            r_selected_reg  <= i_selected_reg;
            r_pc            <= i_pc;
        end
    end

    // Link-register writes take priority over the load/ALU select
    always_comb begin
        w_wb_data = r_alu_result;
        w_wb_reg  = r_selected_reg;
        if (r_last_reg_ctrl) begin
            w_wb_data = NB_DATA'(r_pc);
            w_wb_reg  = c_last_reg;
        end else if (r_mem_to_reg) begin
            w_wb_data = r_mem_data;
        end
    end

    assign o_wb_data = w_wb_data;
    assign o_wb_reg  = w_wb_reg;

    // ------------------------------------------------------------------
    // Saturating debug counters; frozen whenever no capture happens
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_retired <= '0;
            r_cycles  <= '0;
        end else if (w_capture) begin
            if (r_cycles != c_cnt_max) begin
                r_cycles <= r_cycles + 1'b1;
            end
            if (i_valid && (r_retired != c_cnt_max)) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign o_retired = r_retired;
    assign o_cycles  = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Directed and randomized bench for writeback_stage against a
//            transaction-level reference model.
// Revision : 1.0
// ============================================================================
module tb_writeback_stage;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_valid;
    logic [31:0] i_mem_data;
    logic [31:0] i_alu_result;
    logic [4:0]  i_selected_reg;
    logic        i_reg_write;
    logic        i_mem_to_reg;
    logic        i_last_register_ctrl;
    logic [31:0] i_pc;
    logic        i_halt;

    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_reg;
    logic        o_wb_write;
    logic        o_halt;
    logic [31:0] o_retired;
    logic [31:0] o_cycles;

    logic [31:0] sat_wb_data;
    logic [4:0]  sat_wb_reg;
    logic        sat_wb_write;
    logic        sat_halt;
    logic [3:0]  sat_retired;
    logic [3:0]  sat_cycles;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clock = ~i_clock;

    writeback_stage dut (
        .i_clock              (i_clock),
        .i_reset              (i_reset),
        .i_enable             (i_enable),
        .i_valid              (i_valid),
        .i_mem_data           (i_mem_data),
        .i_alu_result         (i_alu_result),
        .i_selected_reg       (i_selected_reg),
        .i_reg_write          (i_reg_write),
        .i_mem_to_reg         (i_mem_to_reg),
        .i_last_register_ctrl (i_last_register_ctrl),
        .i_pc                 (i_pc),
        .i_halt               (i_halt),
        .o_wb_data            (o_wb_data),
        .o_wb_reg             (o_wb_reg),
        .o_wb_write           (o_wb_write),
        .o_halt               (o_halt),
        .o_retired            (o_retired),
        .o_cycles             (o_cycles)
    );

    // Narrow-counter copy sharing the same stimulus, to exercise saturation
    writeback_stage #(.NB_CNT(4)) dut_sat (
        .i_clock              (i_clock),
        .i_reset              (i_reset),
        .i_enable             (i_enable),
        .i_valid              (i_valid),
        .i_mem_data           (i_mem_data),
        .i_alu_result         (i_alu_result),
        .i_selected_reg       (i_selected_reg),
        .i_reg_write          (i_reg_write),
        .i_mem_to_reg         (i_mem_to_reg),
        .i_last_register_ctrl (i_last_register_ctrl),
        .i_pc                 (i_pc),
        .i_halt               (i_halt),
        .o_wb_data            (sat_wb_data),
        .o_wb_reg             (sat_wb_reg),
        .o_wb_write           (sat_wb_write),
        .o_halt               (sat_halt),
        .o_retired            (sat_retired),
        .o_cycles             (sat_cycles)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit          valid;
        bit          rw;
        bit          m2r;
        bit          lr;
        logic [4:0]  rd;
        logic [31:0] md;
        logic [31:0] alu;
        logic [31:0] pc;
    } instr_t;

    instr_t  m_lat;
    bit      m_halted;
    longint  m_retired;
    longint  m_cycles;

    function automatic logic [31:0] sat_cnt(input longint v, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim[31:0] : v[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!i_reset) begin
            m_lat     = '{valid: 0, rw: 0, m2r: 0, lr: 0, rd: '0, md: '0, alu: '0, pc: '0};
            m_halted  = 0;
            m_retired = 0;
            m_cycles  = 0;
        end else if (i_enable && !m_halted) begin
            m_lat = '{valid: i_valid, rw: i_reg_write, m2r: i_mem_to_reg,
                      lr: i_last_register_ctrl, rd: i_selected_reg,
                      md: i_mem_data, alu: i_alu_result, pc: i_pc};
            m_cycles++;
            if (i_valid) m_retired++;
            if (i_valid && i_halt) m_halted = 1;
        end
    endtask

    task automatic check_model();
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        bit          e_wr;
        e_reg  = m_lat.lr ? 5'd31 : m_lat.rd;
        e_data = m_lat.lr ? m_lat.pc : (m_lat.m2r ? m_lat.md : m_lat.alu);
        e_wr   = m_lat.valid && m_lat.rw && (e_reg != 5'd0) && !m_halted;
        check("wb_reg",      32'(o_wb_reg),    32'(e_reg));
        check("wb_data",     o_wb_data,        e_data);
        check("wb_write",    32'(o_wb_write),  32'(e_wr));
        check("halt",        32'(o_halt),      32'(m_halted));
        check("retired",     o_retired,        sat_cnt(m_retired, 32));
        check("cycles",      o_cycles,         sat_cnt(m_cycles, 32));
        check("sat_retired", 32'(sat_retired), sat_cnt(m_retired, 4));
        check("sat_cycles",  32'(sat_cycles),  sat_cnt(m_cycles, 4));
    endtask

    task automatic tick();
        @(posedge i_clock);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic set_in(input bit v, input bit rw, input bit m2r, input bit lr,
                          input bit h, input logic [4:0] rd, input logic [31:0] md,
                          input logic [31:0] alu, input logic [31:0] pc);
        i_valid              = v;
        i_reg_write          = rw;
        i_mem_to_reg         = m2r;
        i_last_register_ctrl = lr;
        i_halt               = h;
        i_selected_reg       = rd;
        i_mem_data           = md;
        i_alu_result         = alu;
        i_pc                 = pc;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint r0;
        i_enable = 1'b1;
        set_in(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        m_lat     = '{valid: 0, rw: 0, m2r: 0, lr: 0, rd: '0, md: '0, alu: '0, pc: '0};
        m_halted  = 0;
        m_retired = 0;
        m_cycles  = 0;
        #2;

        // reset state
        do_reset();
        check("rst_wb_data", o_wb_data, 32'h0);
        check("rst_wb_write", 32'(o_wb_write), 32'h0);
        check("rst_retired", o_retired, 32'h0);

        // ALU write
        set_in(1, 1, 0, 0, 0, 5'd3, 32'h0, 32'h0000_00A5, 32'h0);
        tick();
        check("alu_write", 32'(o_wb_write), 32'h1);
        check("alu_reg", 32'(o_wb_reg), 32'd3);
        check("alu_data", o_wb_data, 32'hA5);
        check("alu_retired", o_retired, 32'd1);
        check("alu_cycles", o_cycles, 32'd1);

        // load then JAL
        set_in(1, 1, 1, 0, 0, 5'd7, 32'hFFFF_FF80, 32'h10, 32'h0);
        tick();
        check("load_data", o_wb_data, 32'hFFFF_FF80);
        check("load_reg", 32'(o_wb_reg), 32'd7);
        set_in(1, 1, 1, 1, 0, 5'd5, 32'hDEAD_BEEF, 32'h44, 32'h0000_0024);
        tick();
        check("jal_reg", 32'(o_wb_reg), 32'd31);
        check("jal_data", o_wb_data, 32'h24);

        // write to r0 and a bubble
        r0 = m_retired;
        set_in(1, 1, 0, 0, 0, 5'd0, 32'h0, 32'h77, 32'h0);
        tick();
        check("r0_write", 32'(o_wb_write), 32'h0);
        set_in(0, 1, 0, 0, 0, 5'd4, 32'h0, 32'h88, 32'h0);
        tick();
        check("bubble_write", 32'(o_wb_write), 32'h0);
        check("bubble_retired", o_retired, 32'(r0 + 1));

        // stall holds the latch and repeats the write
        set_in(1, 1, 0, 0, 0, 5'd2, 32'h0, 32'h0000_1234, 32'h0);
        tick();
        i_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(1, 1, 0, 0, 0, 5'd9 + 5'(k), 32'h0, 32'h5000 + 32'(k), 32'h0);
            tick();
            check("stall_reg", 32'(o_wb_reg), 32'd2);
            check("stall_data", o_wb_data, 32'h1234);
            check("stall_write", 32'(o_wb_write), 32'h1);
        end
        i_enable = 1'b1;
        tick();
        check("unstall_reg", 32'(o_wb_reg), 32'd11);

        // HALT sequence
        do_reset();
        set_in(1, 1, 0, 0, 0, 5'd1, 32'h0, 32'h11, 32'h0);
        tick();
        check("pre_halt_write", 32'(o_wb_write), 32'h1);
        set_in(1, 1, 0, 0, 1, 5'd9, 32'h0, 32'h99, 32'h0);
        tick();
        check("halt_set", 32'(o_halt), 32'h1);
        set_in(1, 1, 0, 0, 0, 5'd2, 32'h0, 32'h22, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("halted_write", 32'(o_wb_write), 32'h0);
            check("halted_retired", o_retired, 32'd2);
        end
        do_reset();
        check("halt_cleared", 32'(o_halt), 32'h0);
        check("halt_rst_cycles", o_cycles, 32'h0);

        // saturation of the narrow counters
        for (int k = 0; k < 20; k++) begin
            set_in(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
            tick();
        end
        check("sat_cycles_final", 32'(sat_cycles), 32'hF);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            i_reset  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            i_enable = ($urandom_range(0, 99) < 80);
            set_in($urandom_range(0, 99) < 85, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 3,
                   5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
